// File: rtl/hack_pkg.sv
// hack_pkg: memory-map defaults, FSM state and decode region types for hack_mem_ctrl
package hack_pkg;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 15;
  localparam int DEF_RAM_DEPTH = 16384;
  localparam int DEF_SCR_BASE  = 16384;
  localparam int DEF_SCR_DEPTH = 8192;
  localparam int DEF_KBD_ADDR  = 24576;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {DEC_RAM, DEC_SCR, DEC_KBD, DEC_NONE} region_t;
endpackage

// File: rtl/hack_sp_ram.sv
// hack_sp_ram: single-port RAM with synchronous read, contents not reset
// Ports: clk, we (write enable), addr, wdata, rdata (registered read of addr)
module hack_sp_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16384,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/hack_mem_ctrl.sv
// hack_mem_ctrl: Hack CPU data-memory controller decoding RAM, screen and keyboard
// Ports: i_clk/i_reset_n (async active-low); CPU side i_req/i_we/i_addr/i_wdata -> o_ready/o_rdata;
// screen side o_scr_addr/o_scr_wdata/o_scr_we, i_scr_rdata; i_kbd async keyboard code; o_bus_err sticky.
// Define HACK_MEM_BUS_ERR_EN to make o_bus_err flag unmapped accesses; otherwise it is tied low.
module hack_mem_ctrl import hack_pkg::*; #(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int RAM_DEPTH   = DEF_RAM_DEPTH,
  parameter int SCR_BASE    = DEF_SCR_BASE,
  parameter int SCR_DEPTH   = DEF_SCR_DEPTH,
  parameter int KBD_ADDR    = DEF_KBD_ADDR,
  parameter int WAIT_STATES = 0
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_req,
  input  logic                         i_we,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic                         o_ready,
  output logic [DATA_W-1:0]            o_rdata,
  output logic [$clog2(SCR_DEPTH)-1:0] o_scr_addr,
  output logic [DATA_W-1:0]            o_scr_wdata,
  output logic                         o_scr_we,
  input  logic [DATA_W-1:0]            i_scr_rdata,
  input  logic [DATA_W-1:0]            i_kbd,
  output logic                         o_bus_err
);
  localparam int RAW = $clog2(RAM_DEPTH);
  localparam int SAW = $clog2(SCR_DEPTH);
  localparam logic [3:0] LAST = 4'(WAIT_STATES - 1);
  function automatic region_t decode(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return x < 32'(RAM_DEPTH) ? DEC_RAM :
           (x >= 32'(SCR_BASE) && x < 32'(SCR_BASE + SCR_DEPTH)) ? DEC_SCR :
           x == 32'(KBD_ADDR) ? DEC_KBD : DEC_NONE;
  endfunction
  state_t            state, state_n;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q, eff_addr;
  logic [DATA_W-1:0] data_q, eff_wdata, ram_rdata, kbd_s1, kbd_s2;
  logic              we_q, eff_we, ram_we, scr_we_q;
  region_t           eff_reg, reg_q;
  // In IDLE the live inputs drive the memories so a zero-wait access commits/reads
  // on the accepting edge; afterwards the latched copies are used.
  always_comb begin
    eff_addr  = state == IDLE ? i_addr : addr_q;
    eff_we    = state == IDLE ? i_we : we_q;
    eff_wdata = state == IDLE ? i_wdata : data_q;
    eff_reg   = decode(eff_addr);
    reg_q     = decode(addr_q);
    state_n   = state == IDLE ? (i_req ? (WAIT_STATES > 0 ? WAIT : RESP) : IDLE) :
                state == WAIT ? (cnt == LAST ? RESP : WAIT) : IDLE;
    ram_we    = i_reset_n && state_n == RESP && eff_we && eff_reg == DEC_RAM;
    o_ready   = state == RESP;
    o_rdata   = state != RESP ? '0 :
                reg_q == DEC_RAM ? ram_rdata :
                reg_q == DEC_SCR ? i_scr_rdata :
                reg_q == DEC_KBD ? kbd_s2 : '0;
  end
  assign o_scr_addr  = SAW'(eff_addr - ADDR_W'(SCR_BASE));
  assign o_scr_wdata = eff_wdata;
  assign o_scr_we    = scr_we_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      kbd_s1   <= '0;
      kbd_s2   <= '0;
      scr_we_q <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= state == WAIT ? cnt + 4'd1 : 4'd0;
      kbd_s1   <= i_kbd;
      kbd_s2   <= kbd_s1;
      scr_we_q <= state_n == RESP && eff_we && eff_reg == DEC_SCR;
      if (state == IDLE && i_req) begin
        addr_q <= i_addr;
        data_q <= i_wdata;
        we_q   <= i_we;
      end
    end
  end
  hack_sp_ram #(.DATA_W(DATA_W), .DEPTH(RAM_DEPTH)) u_ram (
    .clk(i_clk), .we(ram_we), .addr(eff_addr[RAW-1:0]), .wdata(eff_wdata), .rdata(ram_rdata)
  );
`ifdef HACK_MEM_BUS_ERR_EN
  logic err_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) err_q <= 1'b0;
    else if (state == RESP && reg_q == DEC_NONE) err_q <= 1'b1;
  end
  assign o_bus_err = err_q;
`else
  assign o_bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_hack_mem_ctrl.sv
// tb_hack_mem_ctrl: directed bench for hack_mem_ctrl with zero and three wait states
module tb_hack_mem_ctrl;
`ifdef HACK_MEM_BUS_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, we, req0, req3;
  logic [14:0] addr;
  logic [15:0] wdata, kbd, scr_rdata;
  logic ready0, ready3, scr_we0, scr_we3, err0, err3;
  logic [15:0] rdata0, rdata3, scr_wdata0, scr_wdata3;
  logic [12:0] scr_addr0, scr_addr3;
  int n_chk = 0, n_fail = 0;
  logic [15:0] rd, sd;
  logic [12:0] sa;
  int lat, pulses;
  always #5 clk = ~clk;
  hack_mem_ctrl #(.WAIT_STATES(0)) u0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req0), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ready(ready0), .o_rdata(rdata0), .o_scr_addr(scr_addr0), .o_scr_wdata(scr_wdata0),
    .o_scr_we(scr_we0), .i_scr_rdata(scr_rdata), .i_kbd(kbd), .o_bus_err(err0)
  );
  hack_mem_ctrl #(.WAIT_STATES(3)) u3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req3), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ready(ready3), .o_rdata(rdata3), .o_scr_addr(scr_addr3), .o_scr_wdata(scr_wdata3),
    .o_scr_we(scr_we3), .i_scr_rdata(scr_rdata), .i_kbd(kbd), .o_bus_err(err3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic acc(input int sel, input logic w, input logic [14:0] a, input logic [15:0] d,
                     output logic [15:0] r, output int l, output int p,
                     output logic [12:0] s_a, output logic [15:0] s_d);
    @(negedge clk);
    we = w; addr = a; wdata = d;
    if (sel == 0) req0 = 1'b1; else req3 = 1'b1;
    @(posedge clk);
    l = 0; p = 0; r = '0; s_a = '0; s_d = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      l++;
      if (sel == 0 && scr_we0) begin p++; s_a = scr_addr0; s_d = scr_wdata0; end
      if ((sel == 0) ? ready0 : ready3) begin
        r = (sel == 0) ? rdata0 : rdata3;
        break;
      end
    end
    req0 = 1'b0; req3 = 1'b0;
    @(negedge clk);
    if (sel == 0 && scr_we0) p++;
  endtask
  initial begin
    rst_n = 1'b0; we = 1'b0; req0 = 1'b0; req3 = 1'b0;
    addr = '0; wdata = '0; kbd = '0; scr_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready0", ready0, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_scr_we0", scr_we0, 0);
    chk("rst_err0", err0, 0);
    chk("rst_ready3", ready3, 0);
    rst_n = 1'b1;
    acc(0, 1, 15'h0005, 16'h1234, rd, lat, pulses, sa, sd);
    chk("ws0_wr_lat", lat, 1);
    acc(0, 0, 15'h0005, 16'h0000, rd, lat, pulses, sa, sd);
    chk("ws0_rd_lat", lat, 1);
    chk("ws0_rd_data", rd, 16'h1234);
    chk("idle_rdata0", rdata0, 0);
    acc(3, 1, 15'h0000, 16'h0BEE, rd, lat, pulses, sa, sd);
    chk("ws3_wr_lat", lat, 4);
    acc(3, 0, 15'h0000, 16'h0000, rd, lat, pulses, sa, sd);
    chk("ws3_rd_lat", lat, 4);
    chk("ws3_rd_data", rd, 16'h0BEE);
    @(negedge clk);
    we = 1'b0; addr = 15'h0000; req3 = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready3) break;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (ready3) break;
    end
    req3 = 1'b0;
    chk("ws3_b2b_gap", lat, 5);
    chk("ws3_b2b_data", rdata3, 16'h0BEE);
    @(negedge clk);
    acc(0, 1, 15'h4001, 16'hFFFF, rd, lat, pulses, sa, sd);
    chk("scr_wr_lat", lat, 1);
    chk("scr_we_pulses", pulses, 1);
    chk("scr_wr_addr", sa, 1);
    chk("scr_wr_data", sd, 16'hFFFF);
    scr_rdata = 16'hABCD;
    acc(0, 0, 15'h4001, 16'h0000, rd, lat, pulses, sa, sd);
    chk("scr_rd_data", rd, 16'hABCD);
    chk("scr_rd_no_we", pulses, 0);
    @(negedge clk);
    kbd = 16'h0083;
    repeat (3) @(negedge clk);
    acc(0, 0, 15'h6000, 16'h0000, rd, lat, pulses, sa, sd);
    chk("kbd_rd_data", rd, 16'h0083);
    acc(0, 1, 15'h6000, 16'h5A5A, rd, lat, pulses, sa, sd);
    chk("kbd_wr_no_err", err0, 0);
    chk("kbd_wr_no_scr", pulses, 0);
    acc(0, 0, 15'h0005, 16'h0000, rd, lat, pulses, sa, sd);
    chk("ram_kept", rd, 16'h1234);
    scr_rdata = 16'h7777;
    kbd = 16'h0041;
    acc(0, 0, 15'h7000, 16'h0000, rd, lat, pulses, sa, sd);
    chk("unmap_rd_data", rd, 0);
    chk("unmap_err", err0, 32'(ERR_EN));
    repeat (2) @(negedge clk);
    chk("unmap_err_sticky", err0, 32'(ERR_EN));
    acc(3, 1, 15'h0002, 16'h2222, rd, lat, pulses, sa, sd);
    @(negedge clk);
    we = 1'b1; addr = 15'h0002; wdata = 16'h9999; req3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midwait_no_ready", ready3, 0);
    rst_n = 1'b0; req3 = 1'b0;
    @(negedge clk);
    chk("rst_err_clear", err0, 0);
    chk("rst_rdata3", rdata3, 0);
    rst_n = 1'b1;
    acc(3, 0, 15'h0002, 16'h0000, rd, lat, pulses, sa, sd);
    chk("midwait_ram_kept", rd, 16'h2222);
    acc(0, 0, 15'h0005, 16'h0000, rd, lat, pulses, sa, sd);
    chk("ram_survives_rst", rd, 16'h1234);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hack_mem_ctrl.md
HACK_MEM_CTRL -- requirements
Module: hack_mem_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, meaning data word width.
REQ-002 The module SHALL have parameter ADDR_W, default 15, meaning CPU data address width.
REQ-003 The module SHALL have parameter RAM_DEPTH, default 16384, meaning internal RAM words mapped at address 0.
REQ-004 The module SHALL have parameter SCR_BASE, default 16384, and SCR_DEPTH, default 8192, meaning the screen window.
REQ-005 The module SHALL have parameter KBD_ADDR, default 24576, meaning the keyboard register address.
REQ-006 The module SHALL have parameter WAIT_STATES, default 0, range 0..15, meaning extra stall cycles per access.
REQ-007 The module SHALL have one clock and an asynchronous, active-low reset: i_clk  in  1  rising-edge clock; i_reset_n  in  1  asynchronous active-low reset.
REQ-008 The module SHALL have i_req  in  1  access request, held by the CPU until o_ready.
REQ-009 The module SHALL have i_we  in  1  write when 1, read when 0; i_addr  in  ADDR_W  word address; i_wdata  in  DATA_W  write data.
REQ-010 The module SHALL have o_ready  out  1  single-cycle completion strobe; o_rdata  out  DATA_W  read data, valid while o_ready=1.
REQ-011 The module SHALL have o_scr_addr  out  log2(SCR_DEPTH)  screen word address; o_scr_wdata  out  DATA_W  screen write data; o_scr_we  out  1  screen write strobe; i_scr_rdata  in  DATA_W  synchronous screen read data.
REQ-012 The module SHALL have i_kbd  in  DATA_W  asynchronous keyboard code; o_bus_err  out  1  sticky error flag.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 IDLE with i_req=1 SHALL accept the access: latch address, data and i_we, then go to WAIT if WAIT_STATES>0, else RESP.
REQ-015 WAIT SHALL count WAIT_STATES cycles, then go to RESP.
REQ-016 RESP SHALL assert o_ready for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency from the accepting edge to o_ready SHALL be 1+WAIT_STATES cycles; back-to-back throughput SHALL be one access per 2+WAIT_STATES cycles.
REQ-018 i_req and the other inputs SHALL be ignored outside IDLE; the latched copies SHALL be used.
REQ-019 Decode: addr<RAM_DEPTH -> RAM; SCR_BASE<=addr<SCR_BASE+SCR_DEPTH -> screen at offset addr-SCR_BASE; addr==KBD_ADDR -> keyboard; anything else -> unmapped.
REQ-020 RAM and screen writes SHALL commit on the clock edge entering RESP; o_scr_we SHALL pulse for that one cycle only.
REQ-021 A keyboard write SHALL be ignored, without raising an error.
REQ-022 Unmapped reads SHALL return 0 and unmapped writes SHALL have no effect.
REQ-023 i_kbd SHALL pass through a two-flop synchroniser; a keyboard read SHALL return the synchronised value.
REQ-024 o_rdata SHALL be 0 whenever o_ready=0.

Reset
REQ-025 While i_reset_n=0: state=IDLE, o_ready=0, o_scr_we=0, o_rdata=0, o_bus_err=0, wait counter=0, synchroniser flops=0.
REQ-026 A reset asserted during WAIT SHALL discard the pending access, with no RAM or screen write.
REQ-027 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro HACK_MEM_BUS_ERR_EN defined, o_bus_err SHALL set in RESP of any unmapped access and clear only on reset.
REQ-029 Without HACK_MEM_BUS_ERR_EN, o_bus_err SHALL be tied 0 and no error logic SHALL be synthesised.

Structure
REQ-030 Package hack_pkg SHALL hold the memory-map default constants and the FSM state enum typedef.
REQ-031 RAM SHALL be sub-module hack_sp_ram: single-port, synchronous read, parameterised DATA_W and depth.

Verification
REQ-032 WAIT_STATES=0: write 0x1234 @0x0005, then read @0x0005 -> o_ready 1 cycle after each accept, o_rdata=0x1234.
REQ-033 WAIT_STATES=3: read @0x0000 -> o_ready exactly 4 cycles after accept; i_req held high yields the next accept 1 cycle after RESP.
REQ-034 Write 0xFFFF @0x4001 -> o_scr_we pulses once with o_scr_addr=1 and o_scr_wdata=0xFFFF; i_scr_rdata=0xABCD on read @0x4001 -> o_rdata=0xABCD.
REQ-035 i_kbd=0x0083, then read @0x6000 after ≥2 cycles -> o_rdata=0x0083; write @0x6000 -> no effect and o_bus_err stays 0.
REQ-036 With HACK_MEM_BUS_ERR_EN defined, read @0x7000 -> o_rdata=0 and o_bus_err=1 until reset; reset mid-WAIT on write @0x0002 -> RAM[2] unchanged.
